demux8t1_32_reg: RTL and testbench
==================================

Name: demux8t1_32_reg

Overview:
- Registered 1-to-8 distributor for 32-bit words; the write-side counterpart of the 8-to-1 display/source selector.
- It takes one 32-bit input and latches it into one of eight output channel registers. Channel outputs feed peripherals: display banks, LED/GPIO latches, debug taps.
- It supports single addressed writes and a burst mode. In burst mode an internal pointer auto-increments across channels, with wrap-around.

Parameters:
- WIDTH, 32, data width of din and each channel register.
- RST_VAL, 32'h0000_0000, value loaded into every channel register on rst or clr.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  write data.
- s  input  3  channel select: target of a single write; start channel of a burst.
- wr_en  input  1  write strobe, sampled on the rising clk edge.
- start  input  1  burst start request, sampled in IDLE only.
- len  input  3  burst length minus 1 (0 means 1 write, 7 means 8 writes); sampled with start.
- clr  input  1  synchronous clear of all channels and valid flags.
- o0..o7  output  WIDTH each  channel registers.
- valid  output  8  bit k set once channel k has been written since the last reset or clear.
- ptr  output  3  current burst pointer; 0 in IDLE.
- busy  output  1  high while in BURST.
- wr_ack  output  1  one-cycle pulse the cycle after any accepted write.
- done  output  1  one-cycle pulse the cycle after the last burst write.

Behaviour:
- Reset (rst=1, asynchronous):
  - o0..o7 = RST_VAL, valid = 0, ptr = 0, busy = 0, wr_ack = 0, done = 0.
  - State = IDLE; the internal remaining-count register = 0.
- FSM states: IDLE, BURST.
- IDLE:
  - wr_en=1: o[s] <= din, valid[s] <= 1, wr_ack = 1 next cycle.
  - start=1: ptr <= s, remaining count <= len, go to BURST. busy rises the next cycle.
  - start=1 and wr_en=1 in the same cycle: the single write to s is performed, and the burst is also started from s. The first burst write targets s again; there is no special casing.
- BURST:
  - wr_en=1: o[ptr] <= din, valid[ptr] <= 1, wr_ack pulses.
  - If remaining count = 0: go to IDLE, ptr <= 0, done pulses next cycle.
  - Otherwise: ptr <= ptr+1 (mod 8, so 7 wraps to 0) and the count decrements.
  - wr_en=0: hold everything; there is no timeout.
  - start is ignored; s is ignored.
- Wrap-around: a burst from s=6 with len=3 writes channels 6, 7, 0, 1.
- Overlap: len=7 writes all eight channels exactly once; no channel is written twice within one burst.
- clr=1 (any state):
  - All channels <= RST_VAL, valid <= 0, state <= IDLE, ptr <= 0.
  - clr takes priority over wr_en and start in the same cycle. The write is dropped, and wr_ack and done stay 0.
- Latency:
  - A channel output reflects the written din one cycle after the wr_en edge.
  - wr_ack and done are registered and aligned with that output update.
- Unselected channels always hold their value.

Optional Feature:
- Macro: DEMUX8_READBACK_EN.
- Defined:
  - Adds input rd_sel [2:0] and output rd_data [WIDTH-1:0].
  - rd_data is a combinational select of o[rd_sel], for bus readback.
  - Reading the channel written in the same cycle returns the old value (pre-edge).
- Undefined:
  - Ports absent, no readback logic.
  - All other behaviour is identical.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE=1'b0, ST_BURST=1'b1.
  - Channel count constant NCH=8.
  - Pointer width constant PTR_W=3.
- One natural sub-module: demux8_chan_reg, a WIDTH-bit register with load enable, synchronous clear to RST_VAL and asynchronous rst. Eight instances are driven by a one-hot decode of the target index.
- FSM, pointer and counter stay in the top module.

Test Plan:
- Reset mid-burst: start s=2 len=5, two writes, then assert rst -> all o = 0, valid=8'h00, busy=0, ptr=0 immediately (asynchronous).
- Single writes: wr_en s=3 din=32'hDEAD_BEEF, then s=0 din=32'h1 -> o3=DEADBEEF, o0=1, others 0, valid=8'h09, wr_ack pulses twice.
- Wrap burst: start s=6 len=3, four wr_en with din 0xA0..0xA3 -> o6=A0, o7=A1, o0=A2, o1=A3, valid=8'hC3. done pulses once after the fourth write; busy falls the same cycle.
- Burst with gaps: start s=0 len=7, wr_en toggled 1,0,0,1,... for eight writes -> ptr holds during the gaps, all eight channels are written, valid=8'hFF, done occurs once.
- Priority: in BURST with ptr=4, assert clr and wr_en together with din=0x55 -> all o = 0, valid=0, state IDLE, no wr_ack, no done.
- Readback (DEMUX8_READBACK_EN): write o5=32'h1234_5678, then rd_sel=5 -> rd_data=12345678. Same-cycle write o5=0x9 with rd_sel=5 -> rd_data still 12345678 until after the edge.

Source files
------------

// File: rtl/demux8t1_32_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-8 word distributor.
package demux8t1_32_reg_pkg;

  localparam int NCH   = 8;
  localparam int PTR_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic logic [NCH-1:0] onehot(
    input logic [PTR_W-1:0] idx
  );
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux8t1_32_reg_chan.sv
// One channel register: load enable, synchronous clear to RST_VAL,
// asynchronous active-high reset.
module demux8_chan_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (clr) begin
      r_q <= RST_VAL;
    end else if (ld) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/demux8t1_32_reg.sv
// Registered 1-to-8 distributor with single writes and wrapping bursts.
// Optional bus readback mux enabled by defining DEMUX8_READBACK_EN.
module demux8t1_32_reg
  import demux8t1_32_reg_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       s,
  input  logic             wr_en,
  input  logic             start,
  input  logic [2:0]       len,
  input  logic             clr,
`ifdef DEMUX8_READBACK_EN
  input  logic [2:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
`endif
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [7:0]       valid,
  output logic [2:0]       ptr,
  output logic             busy,
  output logic             wr_ack,
  output logic             done
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] r_rem;
  logic [PTR_W-1:0] w_rem_nxt;
  logic [NCH-1:0]   r_valid;
  logic             r_wr_ack;
  logic             r_done;

  logic [PTR_W-1:0] w_tgt;
  logic [NCH-1:0]   w_sel;
  logic             w_wr;
  logic             w_last;
  logic [WIDTH-1:0] w_q [NCH];

  // Clear wins over any write in the same cycle.
  assign w_wr   = wr_en & ~clr;
  assign w_tgt  = (r_state == ST_BURST) ? r_ptr : s;
  assign w_sel  = onehot(w_tgt);
  assign w_last = (r_state == ST_BURST) & w_wr
                & (r_rem == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_ptr_nxt   = '0;
      w_rem_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_BURST;
            w_ptr_nxt   = s;
            w_rem_nxt   = len;
          end
        end
        ST_BURST: begin
          if (wr_en) begin
            if (r_rem == '0) begin
              w_state_nxt = ST_IDLE;
              w_ptr_nxt   = '0;
            end else begin
              w_ptr_nxt = r_ptr + 3'd1;
              w_rem_nxt = r_rem - 3'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
          w_rem_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_rem    <= '0;
      r_valid  <= '0;
      r_wr_ack <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rem    <= w_rem_nxt;
      r_wr_ack <= w_wr;
      r_done   <= w_last;
      if (clr) begin
        r_valid <= '0;
      end else if (w_wr) begin
        r_valid <= r_valid | w_sel;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    demux8_chan_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .ld  (w_wr & w_sel[k]),
      .d   (din),
      .q   (w_q[k])
    );
  end

`ifdef DEMUX8_READBACK_EN
  // Pure mux on the registers: a same-cycle write shows up after the edge.
  assign rd_data = w_q[rd_sel];
`endif

  assign o0     = w_q[0];
  assign o1     = w_q[1];
  assign o2     = w_q[2];
  assign o3     = w_q[3];
  assign o4     = w_q[4];
  assign o5     = w_q[5];
  assign o6     = w_q[6];
  assign o7     = w_q[7];
  assign valid  = r_valid;
  assign ptr    = r_ptr;
  assign busy   = (r_state == ST_BURST);
  assign wr_ack = r_wr_ack;
  assign done   = r_done;

endmodule

// File: tb/tb_demux8t1_32_reg.sv
// Self-checking bench for demux8t1_32_reg against a queue-based model.
// Readback checks are compiled in when DEMUX8_READBACK_EN is defined.
module tb_demux8t1_32_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [2:0]  s;
  logic        wr_en;
  logic        start;
  logic [2:0]  len;
  logic        clr;
  logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  valid;
  logic [2:0]  ptr;
  logic        busy;
  logic        wr_ack;
  logic        done;
`ifdef DEMUX8_READBACK_EN
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux8t1_32_reg dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .s      (s),
    .wr_en  (wr_en),
    .start  (start),
    .len    (len),
    .clr    (clr),
`ifdef DEMUX8_READBACK_EN
    .rd_sel (rd_sel),
    .rd_data(rd_data),
`endif
    .o0     (o0),
    .o1     (o1),
    .o2     (o2),
    .o3     (o3),
    .o4     (o4),
    .o5     (o5),
    .o6     (o6),
    .o7     (o7),
    .valid  (valid),
    .ptr    (ptr),
    .busy   (busy),
    .wr_ack (wr_ack),
    .done   (done)
  );

  logic [31:0] dut_o [8];
  assign dut_o[0] = o0;
  assign dut_o[1] = o1;
  assign dut_o[2] = o2;
  assign dut_o[3] = o3;
  assign dut_o[4] = o4;
  assign dut_o[5] = o5;
  assign dut_o[6] = o6;
  assign dut_o[7] = o7;

  // Model: channel contents, written flags, and the list of
  // channels a running burst still has to visit.
  logic [31:0] m_o [8];
  logic [7:0]  m_valid;
  int          m_todo [$];
  logic        m_ack;
  logic        m_done;

  function automatic logic [2:0] m_ptr();
    return (m_todo.size() != 0) ? 3'(m_todo[0]) : 3'd0;
  endfunction

  function automatic logic m_busy();
    return m_todo.size() != 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_o[k] = 32'h0;
    m_valid = 8'h00;
    m_todo.delete();
    m_ack  = 1'b0;
    m_done = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input logic [31:0] d, input logic [2:0] sel,
                      input logic w, input logic st,
                      input logic [2:0] l, input logic c);
    int t;
    din = d; s = sel; wr_en = w; start = st; len = l; clr = c;
    m_ack  = 1'b0;
    m_done = 1'b0;
    if (c) begin
      for (int k = 0; k < 8; k++) m_o[k] = 32'h0;
      m_valid = 8'h00;
      m_todo.delete();
    end else if (m_todo.size() == 0) begin
      if (w) begin
        m_o[sel]     = d;
        m_valid[sel] = 1'b1;
        m_ack        = 1'b1;
      end
      if (st) begin
        for (int i = 0; i <= int'(l); i++)
          m_todo.push_back((int'(sel) + i) % 8);
      end
    end else if (w) begin
      t          = m_todo.pop_front();
      m_o[t]     = d;
      m_valid[t] = 1'b1;
      m_ack      = 1'b1;
      if (m_todo.size() == 0) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = '0; s = '0; wr_en = 0; start = 0; len = '0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dut_o[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset_o%0d got=%h exp=0", k, dut_o[k]);
      end
    end
    checks++;
    if ({valid, ptr, busy, wr_ack, done} !== 14'h0) begin
      failures++;
      $display("FAIL reset_ctl valid=%h ptr=%0d busy=%b ack=%b done=%b exp=0",
               valid, ptr, busy, wr_ack, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int acks = 0;
    step(32'hDEAD_BEEF, 3'd3, 1, 0, 3'd0, 0);
    acks += int'(wr_ack);
    step(32'h0000_0001, 3'd0, 1, 0, 3'd0, 0);
    acks += int'(wr_ack);
    step(32'h0, 3'd0, 0, 0, 3'd0, 0);
    checks++;
    if (o3 !== 32'hDEAD_BEEF || o0 !== 32'h1) begin
      failures++;
      $display("FAIL single_data o3=%h o0=%h exp=deadbeef/1", o3, o0);
    end
    checks++;
    if (valid !== 8'h09) begin
      failures++;
      $display("FAIL single_valid got=%h exp=09", valid);
    end
    checks++;
    if (acks != 2 || wr_ack !== 1'b0) begin
      failures++;
      $display("FAIL single_ack pulses=%0d last=%b exp=2/0", acks, wr_ack);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dut_o[k] !== m_o[k]) begin
        failures++;
        $display("FAIL single_o%0d got=%h exp=%h", k, dut_o[k], m_o[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int dones = 0;
    step(32'h0, 3'd6, 0, 1, 3'd3, 0);
    checks++;
    if (busy !== 1'b1 || ptr !== 3'd6) begin
      failures++;
      $display("FAIL wrap_start busy=%b ptr=%0d exp=1/6", busy, ptr);
    end
    for (int i = 0; i < 4; i++) begin
      step(32'hA0 + i, 3'd2, 1, 0, 3'd0, 0);
      dones += int'(done);
    end
    checks++;
    if (o6 !== 32'hA0 || o7 !== 32'hA1 || o0 !== 32'hA2 || o1 !== 32'hA3) begin
      failures++;
      $display("FAIL wrap_data o6=%h o7=%h o0=%h o1=%h exp=a0/a1/a2/a3",
               o6, o7, o0, o1);
    end
    checks++;
    if (valid !== 8'hCB) begin
      failures++;
      $display("FAIL wrap_valid got=%h exp=cb", valid);
    end
    checks++;
    if (dones != 1 || done !== 1'b1 || busy !== 1'b0 || ptr !== 3'd0) begin
      failures++;
      $display("FAIL wrap_end dones=%0d done=%b busy=%b ptr=%0d exp=1/1/0/0",
               dones, done, busy, ptr);
    end
    step(32'h0, 3'd0, 0, 0, 3'd0, 0);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL wrap_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_gaps();
    int dones  = 0;
    int writes = 0;
    int cyc    = 0;
    logic [2:0] hold;
    step(32'h0, 3'd0, 1, 0, 3'd0, 1);
    step(32'h0, 3'd0, 0, 1, 3'd7, 0);
    while (writes < 8 && cyc < 40) begin
      hold = ptr;
      if (cyc % 3 == 0) begin
        step(32'hB0 + writes, 3'd5, 1, 1, 3'd2, 0);
        writes++;
      end else begin
        step(32'hFFFF, 3'd5, 0, 1, 3'd2, 0);
        checks++;
        if (ptr !== hold || wr_ack !== 1'b0) begin
          failures++;
          $display("FAIL gap_hold ptr=%0d ack=%b exp=%0d/0", ptr, wr_ack, hold);
        end
      end
      dones += int'(done);
      cyc++;
    end
    checks++;
    if (valid !== 8'hFF || dones != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_end valid=%h dones=%0d busy=%b exp=ff/1/0",
               valid, dones, busy);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dut_o[k] !== 32'hB0 + k) begin
        failures++;
        $display("FAIL gap_o%0d got=%h exp=%h", k, dut_o[k], 32'hB0 + k);
      end
    end
  endtask

  task automatic test_clr_priority();
    step(32'h0, 3'd0, 0, 1, 3'd7, 0);
    for (int i = 0; i < 4; i++) step(32'h10 + i, 3'd0, 1, 0, 3'd0, 0);
    checks++;
    if (ptr !== 3'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_setup ptr=%0d busy=%b exp=4/1", ptr, busy);
    end
    step(32'h55, 3'd4, 1, 1, 3'd0, 1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dut_o[k] !== 32'h0) begin
        failures++;
        $display("FAIL clr_o%0d got=%h exp=0", k, dut_o[k]);
      end
    end
    checks++;
    if ({valid, ptr, busy, wr_ack, done} !== 14'h0) begin
      failures++;
      $display("FAIL clr_ctl valid=%h ptr=%0d busy=%b ack=%b done=%b exp=0",
               valid, ptr, busy, wr_ack, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    step(32'h0, 3'd2, 0, 1, 3'd5, 0);
    step(32'h77, 3'd0, 1, 0, 3'd0, 0);
    step(32'h78, 3'd0, 1, 0, 3'd0, 0);
    wr_en = 1'b0;
    rst   = 1'b1;
    model_reset();
    #1;
    checks++;
    if (o2 !== 32'h0 || o3 !== 32'h0 || valid !== 8'h00
        || busy !== 1'b0 || ptr !== 3'd0) begin
      failures++;
      $display("FAIL async_rst o2=%h o3=%h valid=%h busy=%b ptr=%0d exp=0",
               o2, o3, valid, busy, ptr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic c;
    logic st;
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 31) == 0);
      st = ($urandom_range(0, 5) == 0);
      step($urandom, 3'($urandom), 1'($urandom), st, 3'($urandom), c);
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (dut_o[k] !== m_o[k]) begin
          failures++;
          $display("FAIL rand_o%0d n=%0d got=%h exp=%h", k, n, dut_o[k], m_o[k]);
        end
      end
      checks++;
      if (valid !== m_valid || ptr !== m_ptr() || busy !== m_busy()
          || wr_ack !== m_ack || done !== m_done) begin
        failures++;
        $display("FAIL rand_ctl n=%0d got=%h/%0d/%b/%b/%b exp=%h/%0d/%b/%b/%b",
                 n, valid, ptr, busy, wr_ack, done,
                 m_valid, m_ptr(), m_busy(), m_ack, m_done);
      end
    end
  endtask

`ifdef DEMUX8_READBACK_EN
  task automatic test_readback();
    step(32'h0, 3'd0, 0, 0, 3'd0, 1);
    step(32'h1234_5678, 3'd5, 1, 0, 3'd0, 0);
    rd_sel = 3'd5;
    #1;
    checks++;
    if (rd_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rdback got=%h exp=12345678", rd_data);
    end
    din = 32'h9; s = 3'd5; wr_en = 1'b1;
    #1;
    checks++;
    if (rd_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rdback_pre got=%h exp=12345678", rd_data);
    end
    step(32'h9, 3'd5, 1, 0, 3'd0, 0);
    checks++;
    if (rd_data !== 32'h9) begin
      failures++;
      $display("FAIL rdback_post got=%h exp=9", rd_data);
    end
  endtask
`endif

  initial begin
`ifdef DEMUX8_READBACK_EN
    rd_sel = 3'd0;
`endif
    test_reset();
    test_single();
    test_wrap();
    test_gaps();
    test_clr_priority();
    test_reset_mid_burst();
    test_random();
`ifdef DEMUX8_READBACK_EN
    test_readback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
